// File: rtl/mul_dot_accumulator.sv
// Dot-product accumulator fed by the 32x32 multiplier. A small skid FIFO
// absorbs products, since the multiplier cannot be stalled. Runs of `len`
// products are summed into a wide accumulator, and each finished sum is
// presented on a valid/ready port.
`timescale 1ns/1ps
module mul_dot_accumulator #(
  parameter int ACC_WIDTH  = 72,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [LEN_WIDTH-1:0] i_len,
  input  logic                 i_in_val,
  input  logic [63:0]          i_in_res,
  input  logic                 i_in_ovf,
  input  logic                 i_out_ready,
  output logic                 o_out_val,
  output logic [ACC_WIDTH-1:0] o_out_sum,
  output logic                 o_out_ovf,
  output logic                 o_busy,
  output logic                 o_drop_err
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [64:0]          r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [AW:0]          r_count;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [LEN_WIDTH-1:0] r_cnt, r_len;
  logic                 r_ovf, r_drop;

  logic                 w_empty, w_full, w_pop, w_push, w_drop;
  logic                 w_start, w_last, w_hs;
  logic [64:0]          w_head;
  logic [ACC_WIDTH:0]   w_sum;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign w_pop   = (r_state == S_ACCUM) && !w_empty;
  assign w_push  = i_in_val && (!w_full || w_pop);
  assign w_drop  = i_in_val && w_full && !w_pop;
  assign w_head  = r_mem[r_rd_ptr];
  assign w_sum   = {1'b0, r_acc} + (ACC_WIDTH+1)'(w_head[63:0]);
  assign w_start = (r_state == S_IDLE) && i_start;
  assign w_last  = w_pop && (r_cnt == r_len - LEN_WIDTH'(1));
  assign w_hs    = (r_state == S_DONE) && i_out_ready;

  // FIFO storage. The contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_in_ovf, i_in_res};
  end

  // FIFO pointers and occupancy. The power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic. A zero-length run goes straight to DONE with a zero sum.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start)     w_next = (i_len == '0) ? S_DONE : S_ACCUM;
      S_ACCUM: if (w_last)      w_next = S_DONE;
      S_DONE:  if (i_out_ready) w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  // Accumulator, run counter and overflow tracking. The sum is held through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= '0;
      r_ovf <= 1'b0;
    end else if (w_start) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= i_len;
      r_ovf <= 1'b0;
    end else if (w_pop) begin
      r_acc <= w_sum[ACC_WIDTH-1:0];
      r_cnt <= r_cnt + LEN_WIDTH'(1);
      if (w_sum[ACC_WIDTH] || w_head[64]) r_ovf <= 1'b1;
    end else if (w_hs) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end
  end

  // Sticky lost-product flag. Only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_drop <= 1'b0;
    else if (w_drop) r_drop <= 1'b1;
  end

  assign o_out_val  = (r_state == S_DONE);
  assign o_out_sum  = r_acc;
  assign o_out_ovf  = r_ovf;
  assign o_busy     = (r_state != S_IDLE);
  assign o_drop_err = r_drop;
endmodule

// File: tb/tb_mul_dot_accumulator.sv
// Bench for mul_dot_accumulator. The main DUT uses a 72-bit accumulator.
// A second DUT uses a 64-bit accumulator for the carry-out case.
// Expected sums are queued when each run is started and compared on handshake.
`timescale 1ns/1ps
module tb_mul_dot_accumulator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, en64 = 1'b0, start64;
  logic [7:0]  len = '0;
  logic        in_val = 1'b0, in_ovf = 1'b0, out_ready = 1'b0;
  logic [63:0] in_res = '0;

  logic        out_val, out_ovf, busy, drop_err;
  logic [71:0] out_sum;
  logic        v64, o64, b64, d64;
  logic [63:0] s64;

  always #5 clk = ~clk;
  assign start64 = start & en64;

  mul_dot_accumulator #(.ACC_WIDTH(72), .FIFO_DEPTH(4), .LEN_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_len(len), .i_in_val(in_val),
    .i_in_res(in_res), .i_in_ovf(in_ovf), .i_out_ready(out_ready),
    .o_out_val(out_val), .o_out_sum(out_sum), .o_out_ovf(out_ovf),
    .o_busy(busy), .o_drop_err(drop_err));

  mul_dot_accumulator #(.ACC_WIDTH(64), .FIFO_DEPTH(4), .LEN_WIDTH(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .i_start(start64), .i_len(len), .i_in_val(in_val),
    .i_in_res(in_res), .i_in_ovf(in_ovf), .i_out_ready(out_ready),
    .o_out_val(v64), .o_out_sum(s64), .o_out_ovf(o64),
    .o_busy(b64), .o_drop_err(d64));

  typedef struct packed { logic [71:0] sum; logic ovf; } exp_t;
  typedef struct packed {
    logic [7:0]        len;
    logic [2:0]        np;
    logic [3:0][63:0]  p;
    logic [3:0]        o;
    logic [71:0]       es;
    logic              eo;
  } vec_t;

  exp_t q[$], q64[$];
  exp_t e_m, e_64;
  vec_t tbl[6];
  int   errs = 0, checks = 0, n_hs = 0, n_hs64 = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [7:0] l, input int np, input logic [63:0] a,
                              input logic [63:0] b, input logic [63:0] c, input logic [63:0] d,
                              input logic [3:0] o, input logic [71:0] es, input logic eo);
    vec_t v;
    v.len = l; v.np = 3'(np); v.p[0] = a; v.p[1] = b; v.p[2] = c; v.p[3] = d;
    v.o = o; v.es = es; v.eo = eo;
    return v;
  endfunction

  // Scoreboard check for the main DUT on every handshake.
  always @(negedge clk) begin
    if (rst_n && out_val && out_ready) begin
      if (q.size() == 0) begin
        checks++; errs++;
        $display("FAIL unexpected_out: got sum %0h, expected no output", out_sum);
      end else begin
        e_m = q.pop_front();
        chk("out_sum", out_sum, e_m.sum);
        chk("out_ovf", 72'(out_ovf), 72'(e_m.ovf));
      end
      n_hs++;
    end
  end

  // Scoreboard check for the 64-bit DUT.
  always @(negedge clk) begin
    if (rst_n && v64 && out_ready) begin
      if (q64.size() == 0) begin
        checks++; errs++;
        $display("FAIL unexpected_out64: got sum %0h, expected no output", s64);
      end else begin
        e_64 = q64.pop_front();
        chk("out_sum64", 72'(s64), e_64.sum);
        chk("out_ovf64", 72'(o64), 72'(e_64.ovf));
      end
      n_hs64++;
    end
  end

  task automatic wait_hs(input int target);
    int t = 0;
    while (n_hs < target && t < 60) begin step(); t++; end
    if (n_hs < target) begin
      checks++; errs++;
      $display("FAIL handshake_timeout: got %0d handshakes expected %0d", n_hs, target);
    end
  endtask

  task automatic wait_val();
    int t = 0;
    while (!out_val && t < 20) begin step(); t++; end
    chk("done_reached", 72'(out_val), 72'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int target = n_hs + 1;
    out_ready = 1'b1;
    q.push_back('{sum: v.es, ovf: v.eo});
    start = 1'b1; len = v.len;
    step();
    start = 1'b0;
    for (int k = 0; k < int'(v.np); k++) begin
      in_val = 1'b1; in_res = v.p[k]; in_ovf = v.o[k];
      step();
    end
    in_val = 1'b0; in_ovf = 1'b0;
    wait_hs(target);
    chk("busy_after_hs", 72'(busy), 72'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_val"},  72'(out_val),  72'd0);
    chk({tag, "_sum"},  out_sum,       72'd0);
    chk({tag, "_ovf"},  72'(out_ovf),  72'd0);
    chk({tag, "_busy"}, 72'(busy),     72'd0);
    chk({tag, "_drop"}, 72'(drop_err), 72'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = mk(8'd3, 3, 64'd5, 64'd7, 64'd11, 64'd0, 4'b0000, 72'd23, 1'b0);
    tbl[1] = mk(8'd1, 1, 64'd4, 64'd0, 64'd0, 64'd0, 4'b0001, 72'd4, 1'b1);
    tbl[2] = mk(8'd2, 2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 64'd0,
                4'b0000, 72'h1_0000_0000_0000_0000, 1'b0);
    tbl[3] = mk(8'd0, 0, 64'd0, 64'd0, 64'd0, 64'd0, 4'b0000, 72'd0, 1'b0);
    tbl[4] = mk(8'd4, 4, 64'd1, 64'd2, 64'd3, 64'd4, 4'b0000, 72'd10, 1'b0);
    tbl[5] = mk(8'd2, 2, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'd0, 64'd0,
                4'b0010, 72'h2222_2222_2222_2211, 1'b1);

    // Reset state
    step(); step();
    chk_idle_outputs("rst");
    rst_n = 1'b1;
    step();
    chk_idle_outputs("post_rst");

    // Carry-out at 64 bits versus none at 72 bits
    en64 = 1'b1; out_ready = 1'b1;
    q.push_back('{sum: 72'h1_FFFF_FFFF_FFFF_FFFE, ovf: 1'b0});
    q64.push_back('{sum: 72'h0_FFFF_FFFF_FFFF_FFFE, ovf: 1'b1});
    start = 1'b1; len = 8'd2;
    step();
    start = 1'b0;
    in_val = 1'b1; in_res = 64'hFFFF_FFFF_FFFF_FFFF;
    step(); step();
    in_val = 1'b0;
    wait_hs(1);
    en64 = 1'b0;
    chk("hs64_count", 72'(n_hs64), 72'd1);

    // Table-driven runs
    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Backpressure: sum held while later products queue up
    out_ready = 1'b0;
    q.push_back('{sum: 72'd9, ovf: 1'b0});
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    in_val = 1'b1; in_res = 64'd9;
    step();
    in_res = 64'd1;
    @(negedge clk); chk("lat_cycle1", 72'(out_val), 72'd0);
    step();
    in_res = 64'd2;
    @(negedge clk); chk("lat_cycle2", 72'(out_val), 72'd1);
    step();
    in_res = 64'd3;
    step();
    in_res = 64'd4;
    step();
    in_val = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_val", 72'(out_val), 72'd1);
      chk("hold_sum", out_sum, 72'd9);
      step();
    end
    chk("hold_drop", 72'(drop_err), 72'd0);
    out_ready = 1'b1;
    wait_hs(n_hs + 1);
    run_vec(mk(8'd4, 0, 64'd0, 64'd0, 64'd0, 64'd0, 4'b0000, 72'd10, 1'b0));

    // FIFO overflow while waiting in DONE
    out_ready = 1'b0;
    q.push_back('{sum: 72'd6, ovf: 1'b0});
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    in_val = 1'b1; in_res = 64'd6;
    step();
    in_val = 1'b0;
    wait_val();
    for (int k = 0; k < 5; k++) begin
      in_val = 1'b1; in_res = 64'(10 * (k + 1));
      step();
      if (k == 3) chk("drop_after4", 72'(drop_err), 72'd0);
      if (k == 4) chk("drop_after5", 72'(drop_err), 72'd1);
    end
    in_val = 1'b0;
    step();
    chk("drop_sticky", 72'(drop_err), 72'd1);
    out_ready = 1'b1;
    wait_hs(n_hs + 1);
    run_vec(mk(8'd4, 0, 64'd0, 64'd0, 64'd0, 64'd0, 4'b0000, 72'd100, 1'b0));
    chk("drop_still", 72'(drop_err), 72'd1);

    // len=0 gives out_val on the very next cycle
    out_ready = 1'b0;
    q.push_back('{sum: 72'd0, ovf: 1'b0});
    start = 1'b1; len = 8'd0;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("len0_val", 72'(out_val), 72'd1);
    chk("len0_sum", out_sum, 72'd0);
    step();
    out_ready = 1'b1;
    wait_hs(n_hs + 1);

    // start while busy is ignored, and so is start on the handshake cycle
    out_ready = 1'b0;
    q.push_back('{sum: 72'd3, ovf: 1'b0});
    start = 1'b1; len = 8'd2;
    step();
    start = 1'b1; len = 8'd3; in_val = 1'b1; in_res = 64'd1;
    step();
    start = 1'b0; in_res = 64'd2;
    step();
    in_val = 1'b0;
    wait_val();
    chk("busy_in_done", 72'(busy), 72'd1);
    start = 1'b1; len = 8'd1; out_ready = 1'b1;
    step();
    start = 1'b0;
    chk("hs_start_ignored", 72'(busy), 72'd0);
    step();

    // Reset mid-run: aborted run leaves nothing behind
    out_ready = 1'b1;
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0;
    in_val = 1'b1; in_res = 64'd1; step();
    in_res = 64'd2; step();
    in_res = 64'd5; step();
    in_val = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_val",  72'(out_val), 72'd0);
    chk("midrst_sum",  out_sum,      72'd0);
    chk("midrst_busy", 72'(busy),    72'd0);
    chk("midrst_drop", 72'(drop_err), 72'd0);
    step();
    rst_n = 1'b1;
    step();
    run_vec(mk(8'd1, 1, 64'd3, 64'd0, 64'd0, 64'd0, 4'b0000, 72'd3, 1'b0));

    chk("queue_drained",   72'(q.size()),   72'd0);
    chk("queue64_drained", 72'(q64.size()), 72'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mul_dot_accumulator.md
Name: mul_dot_accumulator

Overview:
- Downstream consumer of the 32x32 multiplier. Captures each registered product (res/val/overflow) into a small skid FIFO and sums a run of `len` products into a wide accumulator.
- Presents each finished dot-product sum on a valid/ready output port.
- The multiplier has no backpressure, so this block must absorb products while the output waits, and must flag any product it loses.

Parameters:
- ACC_WIDTH, 72, accumulator/output width in bits; must be at least 64.
- FIFO_DEPTH, 4, product skid-buffer entries; power of two, at least 2.
- LEN_WIDTH, 8, width of the run-length input.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- len  in  LEN_WIDTH  number of products in the run; latched on an accepted start.
- in_val  in  1  product valid (multiplier val).
- in_res  in  64  product (multiplier res), unsigned.
- in_ovf  in  1  product overflow flag (multiplier overflow), sampled with in_val.
- out_ready  in  1  consumer accepts out_sum.
- out_val  out  1  sum valid.
- out_sum  out  ACC_WIDTH  accumulated sum.
- out_ovf  out  1  run saw a product overflow or an accumulator carry-out.
- busy  out  1  state is not IDLE.
- drop_err  out  1  sticky: a product was lost because the FIFO was full.

Behaviour:
- Reset values (async, rst_n=0):
  - state=IDLE; FIFO empty; acc=0; cnt=0.
  - out_val=0, out_sum=0, out_ovf=0, busy=0, drop_err=0.
- FIFO push/pop rules:
  - Push whenever in_val=1, in every state, storing {in_ovf, in_res}.
  - Pop only in ACCUM, when the FIFO is non-empty.
  - Simultaneous push and pop is legal at any occupancy. When full, a same-cycle pop frees the slot and the push is accepted.
  - Push while full with no pop: the product is discarded and drop_err is set. drop_err clears only on reset.
- IDLE:
  - Products accumulate in the FIFO and are not consumed.
  - start=1: latch len into len_r, clear acc/cnt/ovf_r, and go to ACCUM next cycle.
  - If len=0: go directly to DONE with out_sum=0 and out_ovf=0.
- ACCUM, each cycle the FIFO is non-empty:
  - Pop the head entry.
  - acc <= acc + zero-extended head.res, computed at ACC_WIDTH+1 bits.
  - Carry out of ACC_WIDTH, or head.ovf=1, sets ovf_r. acc wraps modulo 2^ACC_WIDTH.
  - cnt <= cnt + 1.
- Transition to DONE:
  - On the pop where cnt == len_r-1, move to DONE on the next edge.
  - out_sum takes the final acc value, including that pop; out_ovf=ovf_r; out_val=1.
  - Latency: out_val rises exactly 1 cycle after the final pop.
  - A product written to an empty FIFO is popped at the earliest on the cycle after its push edge (FIFO read is registered). Minimum in_val-to-out_val latency for len=1 is 2 cycles.
- DONE:
  - out_val, out_sum and out_ovf are held stable until out_val && out_ready.
  - On that handshake edge: out_val=0, go to IDLE, clear acc.
  - No pops occur in DONE; pushes continue.
- start handling: ignored outside IDLE, including a start coinciding with the DONE handshake. It is recognised from the following IDLE cycle onward.
- busy = (state != IDLE).
- Reset mid-run: everything returns to reset values immediately; FIFO contents are lost; no out_val is generated.

Test Plan:
- Basic run: reset, start with len=3, push products 5, 7, 11 on consecutive cycles, out_ready=1 -> one out_val pulse with out_sum=23, out_ovf=0; busy drops the cycle after the handshake.
- Overflow propagation: len=2, push 0xFFFF_FFFF_FFFF_FFFF twice with ACC_WIDTH=64 -> out_sum=0xFFFF_FFFF_FFFF_FFFE, out_ovf=1. Repeat with ACC_WIDTH=72 -> out_sum=0x1_FFFF_FFFF_FFFF_FFFE, out_ovf=0. Separately, len=1 with in_ovf=1, product 4 -> out_sum=4, out_ovf=1.
- Backpressure and buffering: len=1, push 9, hold out_ready=0 for 10 cycles while pushing 1, 2, 3, 4 -> out_sum=9 held stable, drop_err=0. Then handshake, start len=4 -> out_sum=10.
- FIFO overflow: with out_ready=0 in DONE, push 5 products into the 4-entry FIFO -> drop_err=1 after the fifth push and stays 1. The next len=4 run sums only the first 4 products.
- Edge cases: start with len=0 -> out_val the next cycle with out_sum=0. A start asserted during busy is ignored, with len unchanged. A start on the handshake cycle is ignored.
- Reset mid-run: len=4, after 2 pops assert rst_n=0 for 1 cycle -> all outputs 0, FIFO empty. A new len=1 run with product 3 -> out_sum=3.
